// File: rtl/vend_scheduler.sv
// vend_scheduler: multi-slot vending scheduler. Each coin slot accumulates
// credit in its own lane. A round-robin arbiter hands one shared dispenser to
// one slot at a time. It makes a valid/ready offer, times the dispense, pulses
// candy and deducts PRICE from that slot's credit.
//
// Optional feature macro: CHANGE_RETURN_EN.
//   When it is defined, the vend-complete edge returns the slot's remainder on
//   change/change_valid and clears that slot's credit.
//   When it is not defined, the remainder stays as credit and change/change_valid
//   are tied to 0.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   coin          per-slot coin code, slot i at [2i+1:2i]
//                 (00 none, 01 = 5, 10 = 10, 11 = invalid)
//   disp_ready    dispenser accepts the offer
//   disp_valid    offer to the dispenser (registered)
//   disp_ch       granted slot, meaningful while disp_valid or busy
//   busy          scheduler is in OFFER or VEND
//   candy         one-cycle pulse on the slot whose vend completed
//   coin_err      one-cycle pulse on a slot that presented code 11
//   change_valid  one-cycle change return pulse
//   change        change amount, meaningful only while change_valid is high

// Per-slot credit register. The sum is one bit wider than the credit so that
// saturation and the deduction are resolved on the true value. This assumes
// CW >= 4, so that a full register plus a dime still fits.
module vend_credit_lane #(
  parameter int PRICE = 15,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic          deduct,
  output logic [CW-1:0] credit_q,
  output logic          coin_err_q
);
  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
  localparam logic [CW:0] MAX_W   = {1'b0, {CW{1'b1}}};

  logic [CW:0]   coin_val, sum_w, net_w;
  logic [CW-1:0] credit_d;
  logic          coin_err_d;

  always_comb begin
    case (coin)
      2'b01:   coin_val = (CW+1)'(5);
      2'b10:   coin_val = (CW+1)'(10);
      default: coin_val = '0;
    endcase
    coin_err_d = (coin == 2'b11);
    sum_w      = {1'b0, credit_q} + coin_val;
    // A deduction only happens on a granted slot, and a granted slot holds
    // at least PRICE, so this subtraction never wraps.
    net_w      = deduct ? sum_w - PRICE_W : sum_w;
    credit_d   = (net_w > MAX_W) ? MAX_W[CW-1:0] : net_w[CW-1:0];
`ifdef CHANGE_RETURN_EN
    if (deduct) credit_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q   <= '0;
      coin_err_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      coin_err_q <= coin_err_d;
    end
  end
endmodule

module vend_scheduler #(
  parameter int NUM_CH          = 4,
  parameter int PRICE           = 15,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CW              = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*NUM_CH-1:0]       coin,
  input  logic                      disp_ready,
  output logic                      disp_valid,
  output logic [$clog2(NUM_CH)-1:0] disp_ch,
  output logic                      busy,
  output logic [NUM_CH-1:0]         candy,
  output logic [NUM_CH-1:0]         coin_err,
  output logic                      change_valid,
  output logic [CW-1:0]             change
);
  localparam int CHW = $clog2(NUM_CH);
  localparam int CTW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, VEND} state_t;

  state_t                   state_q, state_d;
  logic [CHW-1:0]           rr_ptr_q, rr_ptr_d, disp_ch_q, disp_ch_d, grant_ch;
  logic [CHW:0]             idx_w;
  logic [CTW-1:0]           cnt_q, cnt_d;
  logic                     disp_valid_q, disp_valid_d, busy_q, busy_d;
  logic                     grant_found, vend_done;
  logic [NUM_CH-1:0]        candy_q, candy_d, req, deduct;
  logic [NUM_CH-1:0][CW-1:0] credit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    vend_credit_lane #(.PRICE(PRICE), .CW(CW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .coin       (coin[2*i +: 2]),
      .deduct     (deduct[i]),
      .credit_q   (credit[i]),
      .coin_err_q (coin_err[i])
    );
    assign req[i] = ({1'b0, credit[i]} >= (CW+1)'(PRICE));
  end

  // Round-robin pick: the first requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx_w       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (CHW+1)'(k);
      if (idx_w >= (CHW+1)'(NUM_CH)) idx_w = idx_w - (CHW+1)'(NUM_CH);
      if (!grant_found && req[idx_w[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = idx_w[CHW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    disp_ch_d    = disp_ch_q;
    disp_valid_d = disp_valid_q;
    cnt_d        = cnt_q;
    candy_d      = '0;
    deduct       = '0;
    vend_done    = 1'b0;
    case (state_q)
      IDLE: if (grant_found) begin
        disp_ch_d    = grant_ch;
        disp_valid_d = 1'b1;
        state_d      = OFFER;
      end
      OFFER: if (disp_valid_q && disp_ready) begin
        disp_valid_d = 1'b0;
        cnt_d        = CTW'(DISPENSE_CYCLES - 1);
        state_d      = VEND;
      end
      VEND: if (cnt_q == '0) begin
        vend_done          = 1'b1;
        deduct[disp_ch_q]  = 1'b1;
        candy_d[disp_ch_q] = 1'b1;
        rr_ptr_d = (disp_ch_q == CHW'(NUM_CH - 1)) ? '0 : disp_ch_q + 1'b1;
        state_d  = IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      disp_ch_q    <= '0;
      disp_valid_q <= 1'b0;
      cnt_q        <= '0;
      candy_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      disp_ch_q    <= disp_ch_d;
      disp_valid_q <= disp_valid_d;
      cnt_q        <= cnt_d;
      candy_q      <= candy_d;
      busy_q       <= busy_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_ch    = disp_ch_q;
  assign busy       = busy_q;
  assign candy      = candy_q;

`ifdef CHANGE_RETURN_EN
  // The remainder includes any coin landing on the granted slot at the
  // vend-complete edge, which matches what the lane would otherwise keep.
  logic          change_valid_q, change_valid_d;
  logic [CW-1:0] change_q, change_d;
  logic [CW:0]   gcoin_w, rem_w;

  always_comb begin
    case (coin[{disp_ch_q, 1'b0} +: 2])
      2'b01:   gcoin_w = (CW+1)'(5);
      2'b10:   gcoin_w = (CW+1)'(10);
      default: gcoin_w = '0;
    endcase
    rem_w          = {1'b0, credit[disp_ch_q]} + gcoin_w - (CW+1)'(PRICE);
    change_valid_d = vend_done;
    change_d       = vend_done ? rem_w[CW-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      change_valid_q <= 1'b0;
      change_q       <= '0;
    end else begin
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
    end
  end

  assign change_valid = change_valid_q;
  assign change       = change_q;
`else
  assign change_valid = 1'b0;
  assign change       = '0;
`endif
endmodule

// File: tb/tb_vend_scheduler.sv
module tb_vend_scheduler;
  localparam int NUM_CH = 4;
  localparam int CW     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        coin = '0;
  logic              disp_ready = 1'b0;
  logic              disp_valid, busy, change_valid;
  logic [1:0]        disp_ch;
  logic [3:0]        candy, coin_err;
  logic [CW-1:0]     change;

  vend_scheduler #(.NUM_CH(NUM_CH), .PRICE(15), .DISPENSE_CYCLES(4), .CW(CW)) dut (
    .clk(clk), .rst(rst), .coin(coin), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_ch(disp_ch), .busy(busy), .candy(candy),
    .coin_err(coin_err), .change_valid(change_valid), .change(change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int cyc; } ev_t;
  ev_t candy_q[$], err_q[$], chg_q[$];
  ev_t me;
  int  checks = 0, errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event is popped from its queue and compared.
  always @(negedge clk) if (rst) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (candy[i]) begin
        if (candy_q.size() == 0) chk("candy_unexpected_ch", i, -1);
        else begin
          me = candy_q.pop_front();
          chk("candy_ch", i, me.val);
          chk("candy_cyc", cyc, me.cyc);
        end
      end
      if (coin_err[i]) begin
        if (err_q.size() == 0) chk("coin_err_unexpected_ch", i, -1);
        else begin
          me = err_q.pop_front();
          chk("coin_err_ch", i, me.val);
          chk("coin_err_cyc", cyc, me.cyc);
        end
      end
    end
    if (change_valid) begin
      if (chg_q.size() == 0) chk("change_unexpected", int'(change), -1);
      else begin
        me = chg_q.pop_front();
        chk("change_amt", int'(change), me.val);
        chk("change_cyc", cyc, me.cyc);
      end
    end
  end

  function automatic logic [7:0] cv(int ch, logic [1:0] code);
    logic [7:0] v;
    v = '0;
    v[2*ch +: 2] = code;
    return v;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle coin; on return cyc is the edge that sampled it.
  task automatic drive(logic [7:0] v);
    coin = v;
    @(negedge clk);
    coin = '0;
  endtask

  task automatic exp_vend(int ch, int c, int rem);
    ev_t e;
    e.val = ch; e.cyc = c;
    candy_q.push_back(e);
`ifdef CHANGE_RETURN_EN
    e.val = rem;
    chg_q.push_back(e);
`endif
  endtask

  task automatic exp_err(int ch, int c);
    ev_t e;
    e.val = ch; e.cyc = c;
    err_q.push_back(e);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_disp_valid"}, disp_valid, 0);
    chk({tag, "_disp_ch"}, disp_ch, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_candy"}, candy, 0);
    chk({tag, "_coin_err"}, coin_err, 0);
    chk({tag, "_change_valid"}, change_valid, 0);
    chk({tag, "_change"}, change, 0);
  endtask

  initial begin
    int k, c;
    tick(2);
    chk_zero("reset");
    rst = 1'b1;
    tick(1);

    // Single vend on ch0: 10 then 5
    disp_ready = 1'b1;
    drive(cv(0, 2'b10)); drive(cv(0, 2'b01)); k = cyc;
    chk("t1_dv_before", disp_valid, 0);
    exp_vend(0, k + 6, 0);
    tick(1);
    chk("t1_dv", disp_valid, 1); chk("t1_ch", disp_ch, 0); chk("t1_busy", busy, 1);
    tick(1);
    chk("t1_dv_drop", disp_valid, 0); chk("t1_busy_vend", busy, 1);
    tick(4);
    chk("t1_idle", busy, 0);
    // credit0 must be 0: a dime alone may not vend
    drive(cv(0, 2'b10)); tick(8);
    drive(cv(0, 2'b01)); k = cyc; exp_vend(0, k + 6, 0); tick(8);

    // Round robin from rr_ptr = 0
    rst = 1'b0; tick(1); rst = 1'b1; tick(1);
    drive(cv(1, 2'b10) | cv(2, 2'b10)); drive(cv(1, 2'b01) | cv(2, 2'b01)); k = cyc;
    exp_vend(1, k + 6, 0); exp_vend(2, k + 12, 0);
    tick(1);  chk("t2_first_ch", disp_ch, 1);
    tick(6);  chk("t2_second_dv", disp_valid, 1); chk("t2_second_ch", disp_ch, 2);
    tick(6);
    // rr_ptr is now 3: ch3 is served ahead of ch0
    drive(cv(0, 2'b10) | cv(3, 2'b10)); drive(cv(0, 2'b01) | cv(3, 2'b01)); k = cyc;
    exp_vend(3, k + 6, 0); exp_vend(0, k + 12, 0);
    tick(1);  chk("t2_rr_ch", disp_ch, 3);
    tick(12);

    // Stall in OFFER for 10 cycles
    disp_ready = 1'b0;
    drive(cv(2, 2'b10)); drive(cv(2, 2'b01)); tick(1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_dv_hold", disp_valid, 1);
      chk("t3_ch_hold", disp_ch, 2);
      tick(1);
    end
    c = cyc; disp_ready = 1'b1;
    exp_vend(2, c + 5, 0);
    tick(7);

    // ch0 credit 20, dime lands on the deduction edge
    disp_ready = 1'b0;
    drive(cv(0, 2'b10)); drive(cv(0, 2'b10)); tick(2);
    c = cyc; disp_ready = 1'b1;
    exp_vend(0, c + 5, 15);
    tick(4); drive(cv(0, 2'b10));
    tick(1);
`ifdef CHANGE_RETURN_EN
    chk("t4_no_rereq", disp_valid, 0);
`else
    chk("t4_rereq", disp_valid, 1); chk("t4_rereq_ch", disp_ch, 0);
    exp_vend(0, c + 11, 0);
`endif
    tick(6);
    drive(cv(0, 2'b10)); tick(8);
    drive(cv(0, 2'b01)); k = cyc; exp_vend(0, k + 6, 0); tick(8);

    // 13 nickels on ch3 while stalled: credit saturates at 63
    disp_ready = 1'b0;
    for (int i = 0; i < 13; i++) drive(cv(3, 2'b01));
    c = cyc; disp_ready = 1'b1;
`ifdef CHANGE_RETURN_EN
    exp_vend(3, c + 5, 48);
    tick(8);
`else
    for (int i = 0; i < 4; i++) exp_vend(3, c + 5 + 6 * i, 0);
    tick(26);
`endif
    // Invalid code on ch3: error pulse, no credit
    drive(cv(3, 2'b11)); k = cyc; exp_err(3, k);
    drive(cv(3, 2'b10)); tick(8);
    drive(cv(3, 2'b01)); k = cyc;
`ifdef CHANGE_RETURN_EN
    exp_vend(3, k + 6, 0);
`else
    exp_vend(3, k + 6, 3);
`endif
    tick(8);

    // Reset in the middle of VEND
    drive(cv(1, 2'b10)); drive(cv(1, 2'b01)); k = cyc;
    tick(4);
    chk("t6_busy_pre", busy, 1);
    rst = 1'b0; #1;
    chk_zero("rst_mid");
    tick(3); rst = 1'b1; tick(10);
    drive(cv(1, 2'b10)); tick(8);
    drive(cv(1, 2'b01)); k = cyc; exp_vend(1, k + 6, 0); tick(8);

    chk("sb_candy_left", candy_q.size(), 0);
    chk("sb_err_left", err_q.size(), 0);
    chk("sb_change_left", chg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
